regfile_wb_stage: RTL and testbench



---
 rtl/regfile_wb_stage.sv | 151 +++++++++++++++
 tb/tb_regfile_wb_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_stage.sv
// Write-back stage and register file: one-cycle pending write with read bypass,
// commit through a hierarchical one-hot decoder, and a sequential clear engine.

module regfile_dec_cell #(
    parameter int IN_W = 2
) (
    input  logic                 en_i,
    input  logic [IN_W-1:0]      sel_i,
    output logic [2**IN_W-1:0]   onehot_o
);
    for (genvar gi = 0; gi < 2**IN_W; gi++) begin : g_line
        assign onehot_o[gi] = en_i && (sel_i == IN_W'(gi));
    end
endmodule

module regfile_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_a_i,
    output logic [DATA_W-1:0] rd_data_a_o,
    input  logic [ADDR_W-1:0] rd_addr_b_i,
    output logic [DATA_W-1:0] rd_data_b_o,
    input  logic              clr_req_i,
    output logic              busy_o,
    output logic              clr_done_o
);
    localparam int NREG = 2**ADDR_W;
    localparam int LO_W = 2;
    localparam int HI_W = ADDR_W - LO_W;

    typedef enum logic {RUN, CLEAR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                clr_done_q, clr_done_d;
    logic                clr_en;

    logic                pend_valid_q;
    logic [ADDR_W-1:0]   pend_addr_q;
    logic [DATA_W-1:0]   pend_data_q;
    logic                wr_accept;

    logic [NREG-1:0]     wr_en;
    logic [2**HI_W-1:0]  hi_line;
    logic [DATA_W-1:0]   regs_rd [NREG];

    assign wr_ready_o = (state_q == RUN) && !clr_req_i;
    assign wr_accept  = wr_valid_i && wr_ready_o;
    assign busy_o     = (state_q == CLEAR);
    assign clr_done_o = clr_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
        end else begin
            pend_valid_q <= wr_accept;
            if (wr_accept) begin
                pend_addr_q <= wr_addr_i;
                pend_data_q <= wr_data_i;
            end
        end
    end

    // Upper address bits select a group, lower bits pick the word within it.
    regfile_dec_cell #(.IN_W(HI_W)) u_dec_hi (
        .en_i     (pend_valid_q),
        .sel_i    (pend_addr_q[ADDR_W-1:LO_W]),
        .onehot_o (hi_line)
    );

    for (genvar gi = 0; gi < 2**HI_W; gi++) begin : g_dec_lo
        regfile_dec_cell #(.IN_W(LO_W)) u_dec_lo (
            .en_i     (hi_line[gi]),
            .sel_i    (pend_addr_q[LO_W-1:0]),
            .onehot_o (wr_en[gi*(2**LO_W) +: (2**LO_W)])
        );
    end

    // $zero has no storage; its decoder line is simply left unconnected.
    assign regs_rd[0] = '0;

    for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
        logic [DATA_W-1:0] word_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q <= '0;
            end else if (clr_en && (idx_q == ADDR_W'(gi))) begin
                word_q <= '0;
            end else if (wr_en[gi]) begin
                word_q <= pend_data_q;
            end
        end

        assign regs_rd[gi] = word_q;
    end

    assign rd_data_a_o = (rd_addr_a_i == '0) ? '0 :
                         (pend_valid_q && (pend_addr_q == rd_addr_a_i)) ? pend_data_q :
                         regs_rd[rd_addr_a_i];
    assign rd_data_b_o = (rd_addr_b_i == '0) ? '0 :
                         (pend_valid_q && (pend_addr_q == rd_addr_b_i)) ? pend_data_q :
                         regs_rd[rd_addr_b_i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            idx_q      <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            clr_done_q <= clr_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        clr_done_d = 1'b0;
        clr_en     = 1'b0;
        case (state_q)
            RUN: begin
                if (clr_req_i) begin
                    state_d = CLEAR;
                    idx_d   = ADDR_W'(1);
                end
            end
            CLEAR: begin
                clr_en = 1'b1;
                if (idx_q == '1) begin
                    state_d    = RUN;
                    idx_d      = '0;
                    clr_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end
endmodule

// File: tb/tb_regfile_wb_stage.sv
// Directed bench for regfile_wb_stage: bypass, $zero, back-to-back writes,
// clear sequencing and reset during clear.

module tb_regfile_wb_stage;
    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [31:0] rd_data_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_b;
    logic        clr_req;
    logic        busy;
    logic        clr_done;

    int checks   = 0;
    int failures = 0;

    regfile_wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid_i  (wr_valid),
        .wr_ready_o  (wr_ready),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .rd_addr_a_i (rd_addr_a),
        .rd_data_a_o (rd_data_a),
        .rd_addr_b_i (rd_addr_b),
        .rd_data_b_o (rd_data_b),
        .clr_req_i   (clr_req),
        .busy_o      (busy),
        .clr_done_o  (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = 5'd5; rd_addr_b = 5'd6; clr_req = 1'b0;
        tick(); tick();
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_clr_done", 32'(clr_done), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_rd_a", rd_data_a, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single write with bypass, then from the array.
        wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        #1;
        chk("w5_offer_not_fwd", rd_data_a, 32'd0);
        tick();
        wr_valid = 1'b0;
        #1;
        chk("w5_bypass", rd_data_a, 32'hDEADBEEF);
        chk("w5_rd_b_r6", rd_data_b, 32'd0);
        tick(); #1;
        chk("w5_array", rd_data_a, 32'hDEADBEEF);
        tick(); #1;
        chk("w5_array2", rd_data_a, 32'hDEADBEEF);

        // $zero is never stored or bypassed.
        wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        rd_addr_a = 5'd0; rd_addr_b = 5'd0;
        tick();
        wr_valid = 1'b0;
        #1;
        chk("r0_pending_a", rd_data_a, 32'd0);
        chk("r0_pending_b", rd_data_b, 32'd0);
        tick(); #1;
        chk("r0_after", rd_data_a, 32'd0);

        // Back-to-back writes.
        wr_valid = 1'b1; wr_addr = 5'd1; wr_data = 32'd1; rd_addr_a = 5'd1; rd_addr_b = 5'd2;
        tick();
        wr_addr = 5'd1; wr_data = 32'd2;
        #1;
        chk("b2b_r1_first", rd_data_a, 32'd1);
        chk("b2b_ready1", 32'(wr_ready), 32'd1);
        tick();
        wr_addr = 5'd2; wr_data = 32'd3;
        #1;
        chk("b2b_r1_second", rd_data_a, 32'd2);
        chk("b2b_ready2", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        #1;
        chk("b2b_r1_third", rd_data_a, 32'd2);
        chk("b2b_r2_bypass", rd_data_b, 32'd3);
        rd_addr_a = 5'd2;
        #1;
        chk("b2b_same_addr", rd_data_a, rd_data_b);
        tick(); #1;
        chk("b2b_r2_array", rd_data_b, 32'd3);

        // Fill r1..r31 with index*0x11.
        for (int i = 1; i < 32; i++) begin
            wr_valid = 1'b1; wr_addr = 5'(i); wr_data = 32'(i * 'h11);
            tick();
        end
        wr_valid = 1'b0;
        tick();
        rd_addr_a = 5'd31; rd_addr_b = 5'd7;
        #1;
        chk("fill_r31", rd_data_a, 32'h20F);
        chk("fill_r7", rd_data_b, 32'h77);

        // Clear with a simultaneous write offer that must be refused.
        clr_req = 1'b1; wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'hABCD;
        #1;
        chk("clr_wr_ready_low", 32'(wr_ready), 32'd0);
        tick();
        clr_req = 1'b0; wr_valid = 1'b0;
        #1;
        chk("clr_write_refused", rd_data_b, 32'h77);
        for (int c = 1; c <= 31; c++) begin
            clr_req = (c == 5);
            #1;
            chk($sformatf("clr_busy_c%0d", c), 32'(busy), 32'd1);
            chk($sformatf("clr_done_c%0d", c), 32'(clr_done), 32'd0);
            chk($sformatf("clr_r31_c%0d", c), rd_data_a, 32'h20F);
            tick();
        end
        clr_req = 1'b0;
        #1;
        chk("clr_end_busy", 32'(busy), 32'd0);
        chk("clr_end_done", 32'(clr_done), 32'd1);
        chk("clr_end_ready", 32'(wr_ready), 32'd1);
        chk("clr_end_r31", rd_data_a, 32'd0);
        tick(); #1;
        chk("clr_done_once", 32'(clr_done), 32'd0);
        for (int i = 1; i < 32; i++) begin
            rd_addr_a = 5'(i);
            #1;
            chk($sformatf("clr_zero_r%0d", i), rd_data_a, 32'd0);
        end

        // Reset in the middle of a clear.
        wr_valid = 1'b1; wr_addr = 5'd20; wr_data = 32'h14;
        tick();
        wr_valid = 1'b0;
        tick();
        rd_addr_a = 5'd20;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        #1;
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_r20_kept", rd_data_a, 32'h14);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(clr_done), 32'd0);
        chk("mid_rst_r20", rd_data_a, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rel_ready", 32'(wr_ready), 32'd1);
        for (int c = 0; c < 25; c++) begin
            tick();
            chk($sformatf("mid_no_done_c%0d", c), 32'(clr_done), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
